// File: rtl/icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : icache_refill_ctrl
// Purpose  : I-cache miss handler; refills a 32-byte line over an AXI4 INCR
//            burst, forwards the critical word and stalls fetch until done.
// Revision : 1.0 - initial release
// ============================================================================
module icache_refill_ctrl #(
    parameter logic [3:0] ARID       = 4'd0,
    parameter int         LINE_WORDS = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    output logic        stall,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] cache_addr,
    input  logic        tag_hit,
    input  logic        tag_valid,
    input  logic        tag_work,
    input  logic [31:0] data_rdata,
    output logic [3:0]  tag_wen,
    output logic [20:0] tag_wdata,
    output logic [7:0]  data_wen,
    output logic [31:0] data_wdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    input  logic        rlast,
    output logic        rready,
    output logic        bus_err
);

    localparam logic [7:0] c_arlen = 8'(LINE_WORDS - 1);
    localparam logic [2:0] c_last  = 3'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_IDLE   = 3'd1,
        S_LOOKUP = 3'd2,
        S_AR     = 3'd3,
        S_REFILL = 3'd4,
        S_WTAG   = 3'd5,
        S_RESUME = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] miss_addr_q, miss_addr_d;
    logic [2:0]  beat_cnt_q, beat_cnt_d;
    logic [31:0] crit_q, crit_d;
    logic        bus_err_q, bus_err_d;

    logic w_hit_out;
    logic w_beat;
    logic w_last;

    // A LOOKUP hit is only honoured while the tag array is live.
    assign w_hit_out = (state_q == S_LOOKUP) && tag_hit && tag_valid && tag_work;
    assign w_beat    = (state_q == S_REFILL) && rvalid;
    assign w_last    = (beat_cnt_q == c_last);

    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        beat_cnt_d  = beat_cnt_q;
        crit_d      = crit_q;
        bus_err_d   = bus_err_q;
        case (state_q)
            S_INIT: begin
                if (tag_work) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (!tag_work) begin
                    state_d = S_INIT;
                end else if (cpu_req) begin
                    state_d     = S_LOOKUP;
                    miss_addr_d = cpu_addr;
                end
            end
            S_LOOKUP: begin
                if (!tag_work) begin
                    state_d = S_INIT;
                end else if (tag_hit && tag_valid) begin
                    if (cpu_req) miss_addr_d = cpu_addr;
                    else         state_d     = S_IDLE;
                end else begin
                    state_d = S_AR;
                end
            end
            S_AR: begin
                if (arready) begin
                    state_d    = S_REFILL;
                    beat_cnt_d = 3'd0;
                end
            end
            S_REFILL: begin
                if (rvalid) begin
                    beat_cnt_d = beat_cnt_q + 3'd1;
                    if (beat_cnt_q == miss_addr_q[4:2]) crit_d = rdata;
                    // The beat count, not rlast, decides when the line is complete.
                    if (rlast != w_last) bus_err_d = 1'b1;
                    if (w_last) state_d = S_WTAG;
                end
            end
            S_WTAG:   state_d = S_RESUME;
            S_RESUME: state_d = S_IDLE;
            default:  state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_INIT;
            miss_addr_q <= 32'd0;
            beat_cnt_q  <= 3'd0;
            crit_q      <= 32'd0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            beat_cnt_q  <= beat_cnt_d;
            crit_q      <= crit_d;
            bus_err_q   <= bus_err_d;
        end
    end

    always_comb begin
        stall      = !((state_q == S_IDLE) || (state_q == S_RESUME) || w_hit_out);
        inst_valid = (state_q == S_RESUME) || w_hit_out;
        inst_data  = 32'd0;
        if (state_q == S_RESUME) inst_data = crit_q;
        else if (w_hit_out)      inst_data = data_rdata;

        // Hits present the next fetch address so the tag array can pipeline.
        case (state_q)
            S_INIT, S_IDLE, S_RESUME: cache_addr = cpu_addr;
            S_LOOKUP:                 cache_addr = w_hit_out ? cpu_addr : miss_addr_q;
            default:                  cache_addr = miss_addr_q;
        endcase
    end

    assign tag_wen    = (state_q == S_WTAG) ? 4'b1111 : 4'b0000;
    assign tag_wdata  = (state_q == S_WTAG) ? {1'b1, miss_addr_q[31:12]} : 21'd0;
    assign data_wen   = w_beat ? (8'b1 << beat_cnt_q) : 8'd0;
    assign data_wdata = w_beat ? rdata : 32'd0;

    assign arid    = ARID;
    assign araddr  = {miss_addr_q[31:5], 5'b0};
    assign arlen   = c_arlen;
    assign arsize  = 3'd2;
    assign arburst = 2'b01;
    assign arvalid = (state_q == S_AR);
    assign rready  = (state_q == S_REFILL);
    assign bus_err = bus_err_q;

endmodule
`default_nettype wire

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
Miss-handling controller placed directly downstream of the I-cache tag array.
- Consumes the tag array's registered hit/valid/work outputs and drives the shared cache index address, tag write port and data-RAM word writes.
- On a miss, fetches the 32-byte line over an AXI4 read burst of 8 x 32-bit beats.
- Forwards the requested (critical) word to the fetch stage and stalls the fetch stage until the line is installed.

Parameters:
ARID, 4'd0, AXI read ID driven on arid.
LINE_WORDS, 8, words per line; fixed at 8 (arlen = 7); any other value is unsupported.

Ports:
clk  in  1  clock
resetn  in  1  reset; asynchronous, active-low
cpu_req  in  1  fetch request valid this cycle
cpu_addr  in  32  fetch address; held stable by the CPU while stall=1
stall  out  1  fetch must hold; request not complete
inst_valid  out  1  inst_data valid this cycle
inst_data  out  32  instruction word (from cache data RAM on hit, forwarded word on refill)
cache_addr  out  32  address to tag and data RAM (index = [11:5])
tag_hit  in  1  tag array hit (registered, 1-cycle latency)
tag_valid  in  1  tag entry valid bit
tag_work  in  1  tag array init sweep done
data_rdata  in  32  data RAM word (1-cycle latency)
tag_wen  out  4  tag write enable (4'b1111 or 0)
tag_wdata  out  21  {1'b1, miss_addr[31:12]}
data_wen  out  8  one-hot word write enable within line
data_wdata  out  32  refill word
arid  out  4  ARID
araddr  out  32  {miss_addr[31:5], 5'b0}
arlen  out  8  8'd7
arsize  out  3  3'd2
arburst  out  2  2'b01 (INCR)
arvalid  out  1  AR valid
arready  in  1  AR ready
rdata  in  32  R data
rvalid  in  1  R valid
rlast  in  1  R last
rready  out  1  R ready
bus_err  out  1  sticky protocol error flag

Behaviour:
States: INIT, IDLE, LOOKUP, AR, REFILL, WTAG, RESUME.

Reset (resetn low, asynchronous):
- State -> INIT.
- All outputs 0 except stall=1 and the constant AXI fields.
- beat_cnt = 0, miss_addr = 0, bus_err = 0.

INIT:
- stall=1, cache_addr=cpu_addr.
- -> IDLE when tag_work=1.

IDLE:
- cache_addr=cpu_addr, stall=0.
- cpu_req=1 -> LOOKUP; latch miss_addr <= cpu_addr.

LOOKUP (tag/data results for the latched address are valid this cycle):
- Hit (tag_hit & tag_valid): inst_valid=1, inst_data=data_rdata, stall=0.
  - cpu_req=1: stay in LOOKUP, latch the new cpu_addr (back-to-back hits, 1 instruction/cycle).
  - Else -> IDLE.
- Miss: stall=1, -> AR.

AR:
- arvalid=1, stall=1.
- Same cycle arvalid & arready -> REFILL, beat_cnt=0.
- arvalid must not drop before the handshake.

REFILL:
- rready=1.
- Each rvalid beat:
  - data_wen = 1 << beat_cnt; data_wdata = rdata.
  - If beat_cnt == miss_addr[4:2], capture crit_word <= rdata.
  - beat_cnt++.
- cache_addr = miss_addr throughout.
- On the 8th beat (beat_cnt==7) -> WTAG, regardless of rlast.
- bus_err set if rlast=1 with beat_cnt!=7, or rlast=0 with beat_cnt==7.
- Stalled rvalid=0 cycles: no writes, counter holds.

WTAG:
- One cycle: tag_wen=4'b1111, tag_wdata={1'b1, miss_addr[31:12]}, cache_addr=miss_addr.

RESUME:
- One cycle: inst_valid=1, inst_data=crit_word, stall=0.
- Next state IDLE; cache_addr=cpu_addr.

Miss penalty:
- Miss detected in LOOKUP; arvalid asserted the next cycle.
- inst_valid from RESUME occurs 2 cycles after the final beat is accepted.

Other rules:
- tag_work falling (tag array re-init) while in IDLE/LOOKUP -> INIT.
- Ignored during AR/REFILL/WTAG; the refill completes first.
- Reset mid-burst: the burst is abandoned. The interconnect is reset by the same resetn, so no stale R beats arrive.
- bus_err clears only on reset.
- stall=1 in every state except IDLE, RESUME and the LOOKUP hit cycle.

Test Plan:
1. Reset held 3 cycles, release; tag_work rises after 128 cycles -> stall=1, arvalid=0 throughout INIT; IDLE one cycle after tag_work=1.
2. cpu_addr=0xBFC00010, miss, arready=1 immediately, 8 beats 0xA0..0xA7 with no gaps, rlast on the 8th -> araddr=0xBFC00000; data_wen 0x01..0x80 in order; tag_wdata=21'h1BFC00; inst_data=0xA4 with inst_valid=1 exactly 2 cycles after the last beat; bus_err=0.
3. Same line refetched at 0xBFC0001C, tag_hit=1, tag_valid=1, data_rdata=0xA7 -> inst_valid in LOOKUP, no arvalid; 4 back-to-back hits give 4 consecutive inst_valid cycles.
4. Miss with arready delayed 5 cycles and rvalid gaps between beats -> arvalid held steady; beat_cnt does not advance on gaps; exactly 8 data_wen pulses.
5. rlast asserted on beat 5 -> bus_err=1 (sticky); refill still waits for 8 beats and completes normally.
6. resetn dropped during beat 3 -> state INIT immediately (asynchronous); rready=0, arvalid=0, data_wen=0 that same cycle; no tag write for the abandoned line.
